// File: rtl/ram_pkg.sv
// Shared widths and word types for the RAM storage block
// and the environment that drives it.
package ram_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/ram_if.sv
// Write/read bus of the RAM: write driver on master,
// storage on slave, passive sampling on monitor.
interface ram_if;
  import ram_pkg::*;

  logic  wr_enb;
  addr_t wr_addr;
  data_t wr_data;
  logic  rd_enb;
  addr_t rd_addr;
  data_t rd_data;
  logic  rd_valid;

  modport master (
    output wr_enb,
    output wr_addr,
    output wr_data,
    output rd_enb,
    output rd_addr,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  wr_enb,
    input  wr_addr,
    input  wr_data,
    input  rd_enb,
    input  rd_addr,
    output rd_data,
    output rd_valid
  );

  modport monitor (
    input wr_enb,
    input wr_addr,
    input wr_data,
    input rd_enb,
    input rd_addr,
    input rd_data,
    input rd_valid
  );

endinterface

// File: rtl/ram_mem_array.sv
// Storage array with async clear, one write port and a
// registered read-first read port.
module ram_mem_array
  import ram_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_enb,
  input  addr_t wr_addr,
  input  data_t wr_data,
  input  logic  rd_enb,
  input  addr_t rd_addr,
  output data_t rd_data
);

  data_t mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_enb) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Same-edge collision returns the pre-write word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_enb) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ram_modport.sv
// Dual-port synchronous RAM behind the ram_if slave modport;
// adds the one-cycle read-valid strobe.
module ram_modport
  import ram_pkg::*;
(
  input logic  clk,
  input logic  rst,
  ram_if.slave bus
);

  data_t rd_data;
  logic  rd_valid;

  ram_mem_array u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_enb  (bus.wr_enb),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_enb  (bus.rd_enb),
    .rd_addr (bus.rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= bus.rd_enb;
    end
  end

  assign bus.rd_data  = rd_data;
  assign bus.rd_valid = rd_valid;

endmodule

// File: tb/tb_ram_modport.sv
// Directed vector bench for ram_modport.
`timescale 1ns/1ps
module tb_ram_modport;
  import ram_pkg::*;

  typedef struct {
    logic  wr_enb;
    addr_t wr_addr;
    data_t wr_data;
    logic  rd_enb;
    addr_t rd_addr;
    logic  exp_valid;
    data_t exp_data;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;
  vec_t vq [$];

  ram_if bus ();

  ram_modport dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic we, addr_t wa, data_t wd, logic re, addr_t ra);
    bus.wr_enb  = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_enb  = re;
    bus.rd_addr = ra;
  endtask

  function automatic vec_t mk(logic we, addr_t wa, data_t wd, logic re,
                              addr_t ra, logic ev, data_t ed, string nm);
    vec_t v;
    v.wr_enb = we; v.wr_addr = wa; v.wr_data = wd;
    v.rd_enb = re; v.rd_addr = ra;
    v.exp_valid = ev; v.exp_data = ed; v.name = nm;
    return v;
  endfunction

  initial begin
    drive(1'b0, '0, '0, 1'b0, '0);
    // reset state: enables ignored while rst low
    tick();
    drive(1'b1, 4'd5, 8'hEE, 1'b1, 4'd5);
    tick();
    check("rst_valid", 32'(bus.rd_valid), 32'h0);
    check("rst_data", 32'(bus.rd_data), 32'h0);
    drive(1'b0, '0, '0, 1'b0, '0);
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      vq.push_back(mk(0, 0, 0, 1, addr_t'(i), 1, 8'h00, "rst_sweep"));
    vq.push_back(mk(1, 3, 8'hA5, 0, 0, 0, 8'h00, "wr3"));
    vq.push_back(mk(0, 0, 0, 1, 3, 1, 8'hA5, "rd3"));
    for (int i = 0; i < DEPTH; i++)
      vq.push_back(mk(1, addr_t'(i), data_t'(i) ^ 8'h5A, 0, 0,
                      0, 8'hA5, "sweep_wr"));
    for (int i = 0; i < DEPTH; i++)
      vq.push_back(mk(0, 0, 0, 1, addr_t'(i), 1,
                      data_t'(i) ^ 8'h5A, "sweep_rd"));
    vq.push_back(mk(1, 7, 8'h11, 0, 0, 0, 8'h55, "wr7"));
    vq.push_back(mk(1, 7, 8'h22, 1, 7, 1, 8'h11, "collide_old"));
    vq.push_back(mk(0, 0, 0, 1, 7, 1, 8'h22, "collide_new"));
    vq.push_back(mk(1, 2, 8'h3C, 0, 0, 0, 8'h22, "wr2"));
    vq.push_back(mk(0, 0, 0, 1, 2, 1, 8'h3C, "rd2"));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(0, 0, 0, 0, 2, 0, 8'h3C, "idle_hold"));
    vq.push_back(mk(1, 0, 8'h77, 1, 15, 1, 8'h55, "indep"));
    vq.push_back(mk(0, 0, 0, 1, 0, 1, 8'h77, "rd0"));
    vq.push_back(mk(1, 15, 8'hFF, 0, 0, 0, 8'h77, "wr15"));
    vq.push_back(mk(0, 0, 0, 1, 15, 1, 8'hFF, "rd15"));

    foreach (vq[i]) begin
      drive(vq[i].wr_enb, vq[i].wr_addr, vq[i].wr_data,
            vq[i].rd_enb, vq[i].rd_addr);
      tick();
      check({vq[i].name, "_valid"}, 32'(bus.rd_valid),
            32'(vq[i].exp_valid));
      check({vq[i].name, "_data"}, 32'(bus.rd_data),
            32'(vq[i].exp_data));
    end

    // reset mid-operation with a read in flight
    drive(1'b0, '0, '0, 1'b1, 4'd0);
    tick();
    check("pre_rst_valid", 32'(bus.rd_valid), 32'h1);
    check("pre_rst_data", 32'(bus.rd_data), 32'h77);
    drive(1'b0, '0, '0, 1'b1, 4'd15);
    #2 rst = 1'b0;
    #1;
    check("async_valid", 32'(bus.rd_valid), 32'h0);
    check("async_data", 32'(bus.rd_data), 32'h0);
    tick();
    check("held_valid", 32'(bus.rd_valid), 32'h0);
    check("held_data", 32'(bus.rd_data), 32'h0);
    rst = 1'b1;
    tick();
    check("post_rd15_valid", 32'(bus.rd_valid), 32'h1);
    check("post_rd15_data", 32'(bus.rd_data), 32'h0);
    drive(1'b0, '0, '0, 1'b1, 4'd3);
    tick();
    check("post_rd3_data", 32'(bus.rd_data), 32'h0);
    drive(1'b0, '0, '0, 1'b0, '0);
    tick();
    check("post_idle_valid", 32'(bus.rd_valid), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_modport.md
Name: ram_modport

Overview:
- Simple dual-port synchronous RAM: one write port, one read port, one clock.
- Write port is driven by the write-driver agent through the interface write modport.
- Read port is sampled by the monitor agent.
- Used as the storage DUT of the RAM layered-verification environment.

Parameters:
- ADDR_WIDTH, 4, address width of both ports; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, width of each stored word and of both data ports.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_enb  input  1  write enable; a write is accepted on a clk rising edge when high.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- rd_enb  input  1  read enable; a read is accepted on a clk rising edge when high.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  high for exactly one cycle when rd_data carries the result of an accepted read.

Behaviour:
- Reset: rst low clears, immediately and asynchronously:
  - every memory word to 0
  - rd_data to 0
  - rd_valid to 0
  - While rst is low, wr_enb and rd_enb are ignored.
  - Deassertion takes effect at the next clk rising edge; the first access is accepted on the first edge with rst high.
- Write:
  - On a rising edge with rst high and wr_enb=1: mem[wr_addr] <= wr_data.
  - No write response output.
  - wr_enb=0 leaves memory unchanged.
- Read:
  - On a rising edge with rst high and rd_enb=1: rd_data <= mem[rd_addr] and rd_valid <= 1.
  - Latency is 1 cycle; data is visible after the edge that sampled rd_enb.
- Idle read cycle:
  - rd_enb=0 sets rd_valid <= 0.
  - rd_data holds its last value; it is not cleared.
- Simultaneous read and write, same address, same edge:
  - Read-first: rd_data returns the old content.
  - The new data is stored and visible to reads on later edges.
- Simultaneous read and write, different addresses: fully independent.
- Back-to-back operations: a read and/or a write can be accepted every cycle.
  - Consecutive reads give continuous rd_valid=1 with a new rd_data each cycle.
- Addressing: every address 0..DEPTH-1 is valid; no out-of-range case exists.
  - Address DEPTH-1 and address 0 are independent locations; no wrap logic.
- Reset mid-operation: a read in flight (rd_valid would assert) is cancelled; rd_valid=0 and rd_data=0 immediately.
- No X propagation: after reset every location reads 0 until written.

Decomposition:
- Package ram_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults
  - localparam DEPTH
  - typedefs addr_t (logic [ADDR_WIDTH-1:0]) and data_t (logic [DATA_WIDTH-1:0])
  - These are shared with the interface and the environment.
- One sub-module, ram_mem_array: storage array with async clear, write port, and registered read-first read port.
- The top ram_modport adds rd_valid generation and the port wiring.

Test Plan:
- Reset check: hold rst=0 for 2 cycles, release, then read addresses 0..15 -> rd_valid=1 each cycle and rd_data=0x00 for all.
- Write-then-read: write 0xA5 to addr 3; next cycle read addr 3 -> one cycle later rd_data=0xA5, rd_valid=1.
- Full sweep:
  - Write addr i with data i^0x5A for i=0..15 back-to-back.
  - Then read 0..15 back-to-back -> rd_data sequence 0x5A,0x5B,0x58,...,0x55 with continuous rd_valid=1.
- Same-address collision:
  - addr 7 holds 0x11.
  - Same edge: write 0x22 to addr 7 and read addr 7 -> rd_data=0x11.
  - Read addr 7 next cycle -> 0x22.
- Idle hold: after reading 0x3C from addr 2, drive rd_enb=0 for 3 cycles -> rd_valid=0, rd_data stays 0x3C.
- Reset mid-operation:
  - Write 0xFF to addr 15; assert rst=0 asynchronously between edges while rd_enb=1 -> rd_data=0 and rd_valid=0 immediately.
  - After release, read addr 15 -> 0x00.
